// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace buffer: record layout,
// drop-counter sizing and a saturating increment helper.
package trace_pkg;

  localparam int unsigned TRACE_REG_W   = 5;
  localparam int unsigned TRACE_DATA_W  = 32;
  localparam int unsigned TRACE_ADDR_W  = 9;
  localparam int unsigned TRACE_CYCLE_W = 32;
  localparam int unsigned DROP_CNT_W    = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  typedef struct packed {
    logic                     reg_we;
    logic                     mem_rd;
    logic                     mem_wr;
    logic [TRACE_REG_W-1:0]   rd_idx;
    logic [TRACE_DATA_W-1:0]  rd_val;
    logic [TRACE_ADDR_W-1:0]  mem_addr;
    logic [TRACE_DATA_W-1:0]  mem_data;
    logic [TRACE_CYCLE_W-1:0] cycle;
  } trace_rec_t;

  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO: element type and power-of-two DEPTH are parameters.
// Head element is read combinationally; flush has priority over push/pop.
module trace_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == FULL_LVL);
    empty   = (count == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign level    = count;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement/memory-probe trace buffer: qualifies and packs core events into
// a FIFO with drop accounting. Optional macro: TRACE_TIMESTAMP_EN (cycle stamps).
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reg_write_sig,
  input  logic [TRACE_REG_W-1:0]  reg_num,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic                    clear,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output trace_rec_t              trace_rec,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count,
  output logic [$clog2(DEPTH):0]  level
);

  logic                     reg_we;
  logic                     mem_access;
  logic                     qualify;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic [TRACE_CYCLE_W-1:0] stamp;
  trace_rec_t               rec_in;
  trace_rec_t               head;

`ifdef TRACE_TIMESTAMP_EN
  logic [TRACE_CYCLE_W-1:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign stamp = cycle_cnt;
`else
  assign stamp = '0;
`endif

  always_comb begin
    reg_we     = reg_write_sig && (reg_num != '0);
    mem_access = wr || rd;
    qualify    = reg_we || mem_access;

    rec_in          = '0;
    rec_in.reg_we   = reg_we;
    rec_in.mem_rd   = rd;
    rec_in.mem_wr   = wr;
    rec_in.rd_idx   = reg_num;
    rec_in.rd_val   = TRACE_DATA_W'(reg_data);
    rec_in.mem_addr = mem_access ? TRACE_ADDR_W'(addr) : '0;
    rec_in.mem_data = wr ? TRACE_DATA_W'(wr_data)
                    : (rd ? TRACE_DATA_W'(rd_data) : '0);
    rec_in.cycle    = stamp;
  end

  // Clear wins over everything: its cycle neither pops, pushes nor drops.
  always_comb begin
    pop  = !empty && trace_ready && !clear;
    push = qualify && !clear && (!full || pop);
    drop = qualify && !clear && full && !pop;
  end

  trace_fifo #(
    .T     (trace_rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (clear),
    .push      (push),
    .push_data (rec_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= drop_sat_inc(drop_count);
    end
  end

  assign trace_valid = !empty;
  assign trace_rec   = trace_valid ? head : '0;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_write_sig = 1'b0;
  logic [4:0]  reg_num = '0;
  logic [31:0] reg_data = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data = '0;
  logic        clear = 1'b0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  trace_rec_t  trace_rec;
  logic        overflow;
  logic [15:0] drop_count;
  logic [4:0]  level;

  int          n_tests = 0;
  int          n_fail  = 0;

  trace_rec_t  model_q[$];
  logic        model_ovf;
  int          model_drops;
  logic [31:0] model_cyc;

  commit_trace_buffer #(.DATA_W(32), .ADDR_W(9), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_write_sig (reg_write_sig),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .wr            (wr),
    .rd            (rd),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .clear         (clear),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_rec     (trace_rec),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .level         (level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic trace_rec_t make_rec(input logic [31:0] cyc);
    trace_rec_t t;
    t          = '0;
    t.reg_we   = reg_write_sig && (reg_num != 5'd0);
    t.mem_rd   = rd;
    t.mem_wr   = wr;
    t.rd_idx   = reg_num;
    t.rd_val   = reg_data;
    t.mem_addr = (wr || rd) ? addr : 9'd0;
    t.mem_data = wr ? wr_data : (rd ? rd_data : 32'd0);
`ifdef TRACE_TIMESTAMP_EN
    t.cycle    = cyc;
`else
    t.cycle    = cyc & 32'h0;
`endif
    return t;
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_ovf   = 1'b0;
    model_drops = 0;
    model_cyc   = '0;
  endtask

  task automatic check_model();
    check_eq("level", 128'(level), 128'(model_q.size()));
    check_eq("valid", 128'(trace_valid), 128'(model_q.size() != 0));
    check_eq("overflow", 128'(overflow), 128'(model_ovf));
    check_eq("drop_count", 128'(drop_count), 128'(model_drops));
    if (model_q.size() != 0) check_eq("rec", 128'(trace_rec), 128'(model_q[0]));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    trace_rec_t rec;
    logic       qual;
    qual = (reg_write_sig && reg_num != 5'd0) || wr || rd;
    rec  = make_rec(model_cyc);
    if (clear) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_drops = 0;
    end else begin
      if (model_q.size() != 0 && trace_ready) void'(model_q.pop_front());
      if (qual) begin
        if (model_q.size() < DEPTH) model_q.push_back(rec);
        else begin
          model_ovf = 1'b1;
          if (model_drops < 65535) model_drops++;
        end
      end
    end
    model_cyc++;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
    clear = 1'b0;
  endtask

  task automatic store(input logic [8:0] a, input logic [31:0] d, input logic rdy);
    idle_inputs();
    wr = 1'b1; addr = a; wr_data = d; trace_ready = rdy;
    tick();
  endtask

  task automatic idle_tick(input logic rdy);
    idle_inputs();
    trace_ready = rdy;
    tick();
  endtask

  task automatic rand_tick(input int ready_pct, input int clear_pct);
    reg_write_sig = 1'($urandom_range(0, 1));
    reg_num       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    reg_data      = $urandom;
    wr            = ($urandom_range(0, 3) == 0);
    rd            = ($urandom_range(0, 3) == 0);
    addr          = 9'($urandom);
    wr_data       = $urandom;
    rd_data       = $urandom;
    clear         = (int'($urandom_range(0, 99)) < clear_pct);
    trace_ready   = (int'($urandom_range(0, 99)) < ready_pct);
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 128'(trace_valid), 128'(0));
    check_eq("rst_level", 128'(level), 128'(0));
    check_eq("rst_overflow", 128'(overflow), 128'(0));
    check_eq("rst_drop", 128'(drop_count), 128'(0));
    check_eq("rst_rec", 128'(trace_rec), 128'(0));
    reset = 1'b1;

    // Single store
    store(9'h004, 32'hDEAD_BEEF, 1'b0);
    check_eq("st_valid", 128'(trace_valid), 128'(1));
    check_eq("st_mem_wr", 128'(trace_rec.mem_wr), 128'(1));
    check_eq("st_addr", 128'(trace_rec.mem_addr), 128'(4));
    check_eq("st_data", 128'(trace_rec.mem_data), 128'(32'hDEADBEEF));
    check_eq("st_reg_we", 128'(trace_rec.reg_we), 128'(0));
    check_eq("st_cycle", 128'(trace_rec.cycle), 128'(0));
    idle_tick(1'b1);

    // Load with writeback
    idle_inputs();
    rd = 1'b1; rd_data = 32'h55; reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h55;
    trace_ready = 1'b0;
    tick();
    check_eq("ld_level", 128'(level), 128'(1));
    check_eq("ld_mem_rd", 128'(trace_rec.mem_rd), 128'(1));
    check_eq("ld_reg_we", 128'(trace_rec.reg_we), 128'(1));
    check_eq("ld_rd_idx", 128'(trace_rec.rd_idx), 128'(7));
    idle_tick(1'b1);

    // x0 write only: not traced
    idle_inputs();
    reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h1234;
    tick();
    check_eq("x0_level", 128'(level), 128'(0));
    check_eq("x0_valid", 128'(trace_valid), 128'(0));

    // 20 events into a stalled FIFO
    for (int i = 0; i < 20; i++) store(9'(i), 32'h1000 + 32'(i), 1'b0);
    check_eq("ovf_level", 128'(level), 128'(16));
    check_eq("ovf_flag", 128'(overflow), 128'(1));
    check_eq("ovf_drops", 128'(drop_count), 128'(4));
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_order", 128'(trace_rec.mem_data), 128'(32'h1000 + 32'(i)));
      idle_tick(1'b1);
    end
    check_eq("drain_empty", 128'(level), 128'(0));

    // Full + pop + push in the same cycle: no drop
    for (int i = 0; i < 16; i++) store(9'(i), 32'h2000 + 32'(i), 1'b0);
    store(9'h1FF, 32'hCAFE_F00D, 1'b1);
    check_eq("fp_drops", 128'(drop_count), 128'(4));
    check_eq("fp_level", 128'(level), 128'(16));
    for (int i = 0; i < 16; i++) idle_tick(1'b1);

    // Clear with entries, event in the clear cycle discarded
    for (int i = 0; i < 5; i++) store(9'(i), 32'h3000 + 32'(i), 1'b0);
    idle_inputs();
    clear = 1'b1; wr = 1'b1; addr = 9'h0AA; wr_data = 32'h0BAD;
    tick();
    check_eq("clr_level", 128'(level), 128'(0));
    check_eq("clr_overflow", 128'(overflow), 128'(0));
    check_eq("clr_drops", 128'(drop_count), 128'(0));

    // Asynchronous reset mid-drain
    for (int i = 0; i < 5; i++) store(9'(i), 32'h4000 + 32'(i), 1'b0);
    idle_tick(1'b1);
    idle_tick(1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_level", 128'(level), 128'(0));
    check_eq("arst_valid", 128'(trace_valid), 128'(0));
    check_eq("arst_overflow", 128'(overflow), 128'(0));
    check_eq("arst_drops", 128'(drop_count), 128'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    store(9'h010, 32'h5555_AAAA, 1'b0);
    check_eq("arst_stamp", 128'(trace_rec.cycle), 128'(0));
    idle_tick(1'b1);

    // Random traffic: balanced, stalled, then with occasional clears
    for (int i = 0; i < 400; i++) rand_tick(60, 0);
    for (int i = 0; i < 60; i++)  rand_tick(5, 0);
    for (int i = 0; i < 400; i++) rand_tick(50, 2);
    for (int i = 0; i < 40; i++)  rand_tick(100, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
